// File: rtl/div_operand_feeder.sv
// Operand sequencer for the non-restoring divider: puts dividend then divisor on the
// shared bus, holds start until done, rejects divide-by-zero and guards with a watchdog.
module div_operand_feeder #(
  parameter int N       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] data_in,
  output logic         start,
  input  logic         done,
  output logic         busy,
  output logic         op_done,
  output logic         dz_err,
  output logic         timeout,
  output logic [7:0]   op_count
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DZ        = 3'd1,
    LOAD_DVD  = 3'd2,
    LOAD_DVS  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      op_count_q, op_count_d;
  logic            op_done_q, op_done_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dvs_q      <= '0;
      wd_q       <= '0;
      op_count_q <= '0;
      op_done_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      wd_q       <= wd_d;
      op_count_q <= op_count_d;
      op_done_q  <= op_done_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    wd_d       = wd_q;
    op_count_d = op_count_q;
    op_done_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = (divisor == '0) ? DZ : LOAD_DVD;
        end
      end
      DZ:       state_d = IDLE;
      LOAD_DVD: state_d = LOAD_DVS;
      LOAD_DVS: begin
        state_d = WAIT_DONE;
        wd_d    = '0;
      end
      WAIT_DONE: begin
        // done wins over an expiring watchdog in the same cycle
        if (done) begin
          state_d    = IDLE;
          op_done_d  = 1'b1;
          op_count_d = op_count_q + 8'd1;
        end else if (wd_q == WD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Everything below decodes registered state only, so no input reaches an output.
  always_comb begin
    in_ready = (state_q == IDLE);
    dz_err   = (state_q == DZ);
    busy     = (state_q == LOAD_DVD) || (state_q == LOAD_DVS) || (state_q == WAIT_DONE);
    start    = busy;
    data_in  = '0;
    if (state_q == LOAD_DVD) data_in = dvd_q;
    if (state_q == LOAD_DVS) data_in = dvs_q;
  end

  assign op_done  = op_done_q;
  assign timeout  = timeout_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_div_operand_feeder.sv
// Scoreboard bench for div_operand_feeder with a behavioural divider driving done.
module tb_div_operand_feeder;

  localparam int N       = 3;
  localparam int TIMEOUT = 8;
  localparam int DIV_LAT = 2;
  localparam int K_NONE = 0, K_TO = 1, K_DZ = 2, K_OP = 4;

  logic         clk, rst, in_valid, in_ready, start, done, busy;
  logic         op_done, dz_err, timeout;
  logic [N-1:0] dividend, divisor, data_in;
  logic [7:0]   op_count;

  logic done_model, done_stray, div_en;
  assign done = done_model | done_stray;

  div_operand_feeder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .data_in(data_in),
    .start(start), .done(done), .busy(busy), .op_done(op_done),
    .dz_err(dz_err), .timeout(timeout), .op_count(op_count)
  );

  typedef struct {
    int         kind;
    int         dvd;
    int         dvs;
    int         q;
    int         r;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_count = 0;
  int         mq, mr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a pair, wait for acceptance, and record what the scoreboard should see.
  task automatic send(input int a, input int b, input int kind, input bit hold);
    exp_t e;
    int   waited;
    dividend = N'(a);
    divisor  = N'(b);
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      chk("accept_wait", 0, 1);
    end else begin
      if (kind != K_NONE) begin
        if (kind == K_OP) exp_count = exp_count + 8'd1;
        e.kind = kind;
        e.dvd  = a;
        e.dvs  = b;
        e.q    = (b != 0) ? a / b : 0;
        e.r    = (b != 0) ? a % b : 0;
        e.cnt  = exp_count;
        sb.push_back(e);
      end
      step();
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (!in_ready && waited < 100) begin
      step();
      waited++;
    end
    if (!in_ready) chk("idle_wait", 0, 1);
    step();
  endtask

  // Behavioural divider: latches the two bus words and answers DIV_LAT cycles later.
  initial begin
    int msc, ma, mb;
    done_model = 1'b0;
    msc = 0; ma = 0; mb = 0; mq = 0; mr = 0;
    forever begin
      @(posedge clk);
      #1;
      if (start) msc++;
      else msc = 0;
      if (msc == 1) ma = int'(data_in);
      if (msc == 2) mb = int'(data_in);
      done_model = div_en && (msc == 2 + DIV_LAT);
      if (done_model) begin
        mq = (mb != 0) ? ma / mb : 0;
        mr = (mb != 0) ? ma % mb : 0;
      end
    end
  end

  // Output monitor: every pulse pops one expectation.
  initial begin
    int   scnt, bus_a, bus_b;
    exp_t e;
    scnt = 0; bus_a = 0; bus_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0;
      end else begin
        if (start) begin
          scnt++;
          if (scnt == 1) bus_a = int'(data_in);
          else if (scnt == 2) bus_b = int'(data_in);
        end else begin
          scnt = 0;
        end
        if (op_done || dz_err || timeout) begin
          if (sb.size() == 0) begin
            chk("unexpected_pulse", {29'd0, op_done, dz_err, timeout}, 0);
          end else begin
            e = sb.pop_front();
            chk("pulse_kind", {29'd0, op_done, dz_err, timeout}, e.kind);
            chk("op_count", op_count, e.cnt);
            if (e.kind == K_OP) begin
              chk("bus_dvd", bus_a, e.dvd);
              chk("bus_dvs", bus_b, e.dvs);
              chk("quotient", mq, e.q);
              chk("remainder", mr, e.r);
            end
            $display("txn kind=%0d dvd=%0d dvs=%0d op_count=%0d", e.kind, e.dvd, e.dvs, op_count);
          end
        end
      end
    end
  end

  initial begin
    bit seen;
    int first;
    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
    div_en = 1'b1; done_stray = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // reset values, then a quiet idle stretch
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data_in", data_in, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_dz_err", dz_err, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_op_count", op_count, 0);
    seen = 0;
    repeat (10) begin
      step();
      seen |= start;
    end
    chk("idle_start", seen, 0);

    // normal 7 / 3
    send(7, 3, K_OP, 0);
    chk("ld_dvd_bus", data_in, 7);
    chk("ld_dvd_start", start, 1);
    chk("ld_dvd_ready", in_ready, 0);
    step();
    chk("ld_dvs_bus", data_in, 3);
    chk("ld_dvs_start", start, 1);
    wait_idle();
    chk("norm_count", op_count, 1);

    // divide by zero
    send(5, 0, K_DZ, 0);
    chk("dz_pulse", dz_err, 1);
    chk("dz_start", start, 0);
    chk("dz_ready", in_ready, 0);
    step();
    chk("dz_ready2", in_ready, 1);
    chk("dz_pulse_once", dz_err, 0);
    chk("dz_start2", start, 0);
    chk("dz_count", op_count, exp_count);

    // watchdog: first WAIT_DONE cycle is cycle 1
    div_en = 1'b0;
    send(6, 2, K_TO, 0);
    step();
    step();
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      if (timeout && first == 0) begin
        first = k;
        chk("to_start", start, 0);
        chk("to_ready", in_ready, 1);
      end
      step();
    end
    chk("to_cycle", first, TIMEOUT + 1);
    chk("to_count", op_count, exp_count);
    div_en = 1'b1;

    // stray done in IDLE and in LOAD_DVS
    done_stray = 1'b1;
    step();
    done_stray = 1'b0;
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_ready", in_ready, 1);
    chk("stray_idle_opdone", op_done, 0);
    send(4, 2, K_OP, 0);
    step();
    done_stray = 1'b1;
    step();
    done_stray = 1'b0;
    chk("stray_dvs_opdone", op_done, 0);
    chk("stray_dvs_busy", busy, 1);
    wait_idle();

    // reset during WAIT_DONE drops the op silently
    div_en = 1'b0;
    send(5, 1, K_NONE, 0);
    repeat (3) step();
    chk("midop_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    exp_count = 8'd0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_start", start, 0);
    chk("midrst_count", op_count, 0);
    chk("midrst_pulses", {op_done, dz_err, timeout}, 0);
    step();
    chk("midrst_pulses2", {op_done, dz_err, timeout}, 0);
    div_en = 1'b1;

    // 256 back-to-back operations wrap the counter
    for (int i = 0; i < 256; i++) begin
      send(int'($urandom_range(7, 0)), int'($urandom_range(7, 1)), K_OP, 1);
    end
    in_valid = 1'b0;
    wait_idle();
    step();
    chk("wrap_count", op_count, 0);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/div_operand_feeder.md
# div_operand_feeder

Upstream sequencing stage for the non-restoring divider (datapath plus controller). It accepts a dividend/divisor pair over a valid/ready handshake and drives the divider's shared `data_in` bus: dividend first, divisor on the next cycle. It holds `start` until the divider raises `done`. It also screens out divide-by-zero, bounds the wait with a watchdog, and counts completed operations.

## Interface
- `N`, default 3: operand width; must match the divider's `N`.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT_DONE before abort (≥2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  feeder can accept a pair.
- `dividend`  in  N  dividend, sampled on handshake.
- `divisor`  in  N  divisor, sampled on handshake.
- `data_in`  out  N  to divider `data_in`.
- `start`  out  1  to divider controller `start`.
- `done`  in  1  from divider controller `done`.
- `busy`  out  1  operation in flight.
- `op_done`  out  1  one-cycle pulse: divider finished normally.
- `dz_err`  out  1  one-cycle pulse: pair rejected, divisor = 0.
- `timeout`  out  1  one-cycle pulse: watchdog abort.
- `op_count`  out  8  completed-operation counter; wraps 255→0.

## Operation
- Handshake: transfer when `in_valid && in_ready` at a rising edge. `dividend` and `divisor` are captured into internal registers `dvd_r` and `dvs_r`. `in_ready` = 1 only in IDLE.
- States: IDLE, DZ, LOAD_DVD, LOAD_DVS, WAIT_DONE.
- IDLE:
  - transfer with divisor ≠ 0 → LOAD_DVD;
  - transfer with divisor = 0 → DZ;
  - otherwise stay in IDLE.
- DZ: `dz_err`=1 for this one cycle only; the divider is never started. Next state is IDLE.
- LOAD_DVD: `data_in`=`dvd_r`, `start`=1. Next state is LOAD_DVS unconditionally.
- LOAD_DVS: `data_in`=`dvs_r`, `start`=1. Next state is WAIT_DONE; the watchdog counter clears to 0.
- WAIT_DONE: `start`=1, `data_in`=0.
  - `done`=1 → IDLE; `op_done` pulses and `op_count` increments on that edge.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with `done` still low → IDLE with a `timeout` pulse; `op_count` is unchanged.
  - `done` takes priority over timeout on the same cycle.
- `done` is ignored in every state except WAIT_DONE.
- `data_in`=0 in every state except LOAD_DVD and LOAD_DVS.
- `busy`=1 in LOAD_DVD, LOAD_DVS and WAIT_DONE.
- Watchdog counter width: clog2(TIMEOUT) bits, unsigned; it is never compared beyond TIMEOUT-1.
- Reset: state→IDLE; `op_count`, the watchdog counter, `dvd_r` and `dvs_r` → 0.
  - Reset values of all outputs: `in_ready`=1, `data_in`=0, `start`=0, `busy`=0, `op_done`=0, `dz_err`=0, `timeout`=0, `op_count`=0.
  - Reset has priority over every other event, including a mid-operation `done` or handshake. An in-flight operation is dropped silently, with no pulse.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Normal operation, handshake at edge E0:
  - cycle after E0: LOAD_DVD (dividend on bus, `start`=1);
  - next cycle: LOAD_DVS (divisor on bus);
  - following cycles: WAIT_DONE.
- If `done` is first sampled high at edge Ed, then in the cycle after Ed: IDLE, `start`=0, `op_done`=1, `in_ready`=1.
- Minimum turnaround: handshake → `op_done` = 3 cycles plus the divider latency. A new pair can be accepted in the same cycle `op_done` is high.
- Divide-by-zero: handshake at E0 → `dz_err`=1 in the cycle after E0 → `in_ready`=1 again one cycle later.
- Timeout: the `timeout` pulse appears TIMEOUT+1 cycles after entry into WAIT_DONE, counting the exit edge.
- Back-to-back: `in_valid` held high with a stream of pairs gives one transfer per completed operation; no pair is lost or duplicated.

## Test plan
- Reset then idle: outputs equal their reset values; with `in_valid`=0 for 10 cycles, `start` never rises.
- Normal op, N=3: dividend=7, divisor=3 with the real divider attached.
  - Required: `data_in`=7 then 3 on consecutive cycles with `start`=1.
  - Required: after `done`, one `op_done` pulse, `op_count`=1, and the divider's quotient=2 and remainder=1.
- Divide by zero: dividend=5, divisor=0.
  - Required: one `dz_err` pulse, `start` stays 0, `op_count` unchanged, `in_ready` high two cycles after the handshake.
- Timeout: `done` tied 0, TIMEOUT=8, dividend=6, divisor=2.
  - Required: `timeout` pulses exactly 9 cycles after WAIT_DONE entry, then `start`=0 and `in_ready`=1.
- Stray `done`: `done` pulsed during IDLE and during LOAD_DVS.
  - Required: no state change and no `op_done`; completion happens only on a WAIT_DONE `done`.
- Reset mid-op and wrap:
  - `rst` asserted during WAIT_DONE → IDLE next cycle, no pulses.
  - 256 completed operations → `op_count` wraps back to 0.
